// File: rtl/fir_sample_sequencer.sv
// Host-side sequencer for a start/done FIR filter: buffers samples, issues them
// one at a time, then rounds/saturates each wide result onto a valid/ready stream.
module fir_sample_sequencer #(
    parameter int WIDTH      = 16,
    parameter int LENGTH     = 38,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAC_SHIFT = 15,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WIDTH-1:0]  fir_x,
    output logic              fir_ready,
    input  logic [LENGTH-1:0] fir_y,
    input  logic              fir_done,
    output logic [WIDTH-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              timeout_err,
    output logic [15:0]       sample_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int L1 = LENGTH + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
    localparam logic signed [LENGTH:0] RND     = L1'(1) << (FRAC_SHIFT - 1);
    localparam logic signed [LENGTH:0] SAT_MAX = (L1'(1) << (WIDTH - 1)) - L1'(1);
    localparam logic signed [LENGTH:0] SAT_MIN = -(L1'(1) << (WIDTH - 1));

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid holds and data stays stable until that edge.
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

    state_t          state, next_state;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            fifo_full, fifo_empty, push, go_issue, timed_out, result_in;
    logic [CW-1:0]   wait_cnt;
    logic signed [LENGTH:0] y_ext, y_rnd, y_shf;
    logic [WIDTH-1:0] scaled;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign s_ready    = rst && !fifo_full;
    assign push       = s_valid && s_ready;
    assign fir_ready  = (state == ISSUE);
    assign busy       = (state != IDLE);
    assign result_in  = (state == WAIT) && fir_done;
    assign timed_out  = (state == WAIT) && !fir_done && (wait_cnt == LAST_CNT);

    // Rounding add is done one bit wider so the largest fir_y cannot wrap.
    assign y_ext = $signed({fir_y[LENGTH-1], fir_y});
    assign y_rnd = y_ext + RND;
    assign y_shf = y_rnd >>> FRAC_SHIFT;

    always_comb begin
        scaled = WIDTH'(y_shf);
        if (y_shf > SAT_MAX)
            scaled = WIDTH'(SAT_MAX);
        else if (y_shf < SAT_MIN)
            scaled = WIDTH'(SAT_MIN);
    end

    always_comb begin
        next_state = state;
        go_issue   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && (!m_valid || m_ready)) begin
                    next_state = ISSUE;
                    go_issue   = 1'b1;
                end
            end
            ISSUE:   next_state = WAIT;
            WAIT:    if (fir_done || (wait_cnt == LAST_CNT)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= s_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fir_x        <= '0;
            wait_cnt     <= '0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            timeout_err  <= 1'b0;
            sample_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            // The head is popped on the edge entering ISSUE so fir_x is already
            // valid during the fir_ready cycle.
            if (go_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
                fir_x  <= mem[rd_ptr[AW-1:0]];
            end
            if (state == ISSUE)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            if (result_in) begin
                m_data       <= scaled;
                m_valid      <= 1'b1;
                sample_count <= sample_count + 16'd1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (timed_out)
                timeout_err <= 1'b1;
        end
    end

endmodule

// File: doc/fir_sample_sequencer.md
Name: fir_sample_sequencer

Overview:
- Host-side counterpart of the FIR filter start/done interface.
- Buffers upstream samples in a small FIFO and issues one sample at a time to the filter: drives `fir_x`, then pulses `fir_ready`.
- Waits for the filter's `fir_done`, then rescales the wide accumulator result to WIDTH bits with rounding and saturation.
- Presents the result downstream on a valid/ready stream; sits between the sample source and the filter top.

Parameters:
- WIDTH, 16, sample width (signed) on both upstream and downstream streams.
- LENGTH, 38, width of the filter result `fir_y` (signed).
- FIFO_DEPTH, 4, input sample FIFO entries; power of two, at least 2.
- FRAC_SHIFT, 15, arithmetic right shift applied to `fir_y`; at least 1.
- TIMEOUT, 255, maximum cycles spent in WAIT before abort; at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- s_data  in  WIDTH  upstream sample, signed.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  FIFO can accept a sample.
- fir_x  out  WIDTH  sample to filter input.
- fir_ready  out  1  one-cycle start pulse to filter.
- fir_y  in  LENGTH  filter result, signed.
- fir_done  in  1  filter result valid, one-cycle pulse.
- m_data  out  WIDTH  scaled result, signed.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts.
- busy  out  1  FSM not in IDLE.
- timeout_err  out  1  sticky; set when a WAIT times out.
- sample_count  out  16  completed results; wraps at 65535 to 0.

Behaviour:
- Reset (rst=0, async): FSM to IDLE and FIFO emptied.
  - Held at 0 during reset: fir_x, fir_ready, m_data, m_valid, busy, timeout_err, sample_count, wait counter, s_ready.
- s_ready = !fifo_full, forced 0 while rst=0.
  - Push when s_valid & s_ready.
  - Push and pop in the same cycle are both legal.
  - When the FIFO is full there is no push, and s_data is ignored.
- FSM states IDLE, ISSUE, WAIT.
- IDLE:
  - Go to ISSUE when the FIFO is not empty and the output slot is free, i.e. m_valid=0, or m_valid & m_ready in this cycle.
  - fir_done is ignored in IDLE.
- ISSUE, one cycle:
  - Pop the FIFO head into the fir_x register; fir_x is valid the cycle fir_ready=1.
  - fir_ready=1 for exactly this one cycle.
  - Clear the wait counter, then go to WAIT.
- WAIT:
  - fir_x is held stable and fir_ready=0.
  - The wait counter increments each cycle.
  - On fir_done=1: capture the scaled result into m_data, set m_valid=1 on the next edge, increment sample_count, go to IDLE.
  - If the counter reaches TIMEOUT without fir_done: set timeout_err, drop the sample with no output and no count, go to IDLE.
  - If fir_done arrives in the same cycle the counter reaches TIMEOUT, fir_done wins.
- Minimum sample period is 2 cycles plus the filter latency. Latency from fir_done to m_valid is 1 cycle.
- Scaling:
  - r = (fir_y + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, computed in LENGTH+1 bits, so round half toward +inf.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Output stream:
  - m_valid stays high and m_data stable until m_ready=1.
  - m_valid clears on the accept edge unless a new result lands on that same edge.
- busy = (state != IDLE).
- timeout_err clears only on reset.
- Reset mid-WAIT: all state is discarded. A late fir_done after reset is ignored, since the FSM is in IDLE.

Test Plan:
- Single sample: push s_data=0x1000; model returns fir_y=2^29 four cycles after fir_ready.
  - Required: exactly one fir_ready pulse with fir_x=0x1000; m_data=0x4000, m_valid=1 one cycle after fir_done; sample_count=1.
- Rounding:
  - fir_y=16384 gives m_data=0x0001.
  - fir_y=16383 gives m_data=0x0000.
  - fir_y=-16384 gives m_data=0x0000.
  - fir_y=-16385 gives m_data=0xFFFF.
- Saturation:
  - fir_y=2^31 gives m_data=0x7FFF.
  - fir_y=-2^31 gives m_data=0x8000.
- Backpressure: hold m_ready=0 with one result pending, push 4 samples.
  - Required: FIFO full, s_ready=0, no further fir_ready, m_data unchanged.
  - Raise m_ready: the remaining samples issue in FIFO order, and one result is delivered per accept.
- Timeout: never assert fir_done.
  - Required: timeout_err=1 exactly TIMEOUT cycles after entering WAIT, no m_valid, FSM in IDLE.
  - The next sample then completes normally.
- Reset mid-WAIT: assert rst=0 during WAIT, release, then pulse fir_done.
  - Required: all outputs 0 during reset; no m_valid afterwards; sample_count=0.
